imm_encode_loader: RTL

Pipelined RISC-V immediate encoder and instruction-memory write streamer: the inverse of the pipeline's immediate sign-extension path. It accepts a base instruction word, an immediate value and an immediate-format code over a valid/ready handshake. It range-checks the immediate, scatters its bits into the format's instruction fields, and emits the finished word with a sequential instruction-memory write address. It sits between the test/boot loader and the instruction memory write port.

---
 rtl/imm_encode_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imm_encode_loader.sv
// RISC-V immediate encoder with sequential instruction-memory write addressing.
// Optional legality checking and error counters are enabled by defining IMM_ENC_CHECK_EN.
module imm_encode_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [31:0]       base_instr,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        err_cnt,
    output logic              err_sticky
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_U = 3'b010;
    localparam logic [2:0] SRC_B = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] base;
        logic [31:0] imm;
    } item_t;

    item_t       s1_q;
    logic        s1_valid;
    logic        s1_bad_c;
    logic        s2_load_c;
    logic        s1_adv_c;
    logic        in_xfer_c;
    logic        out_xfer_c;
    logic        s1_pass_c;
    logic [31:0] enc_c;

    // Legality of the item held in stage 1 (only meaningful while s1_valid).
`ifdef IMM_ENC_CHECK_EN
    always_comb begin
        s1_bad_c = 1'b0;
        case (s1_q.src)
            SRC_I, SRC_S: s1_bad_c = !((&s1_q.imm[31:11]) || !(|s1_q.imm[31:11]));
            SRC_B:        s1_bad_c = !((&s1_q.imm[31:12]) || !(|s1_q.imm[31:12])) || s1_q.imm[0];
            SRC_J:        s1_bad_c = !((&s1_q.imm[31:20]) || !(|s1_q.imm[31:20])) || s1_q.imm[0];
            SRC_U:        s1_bad_c = |s1_q.imm[11:0];
            default:      s1_bad_c = 1'b1;
        endcase
    end
`else
    assign s1_bad_c = 1'b0;
`endif

    // Scatter immediate bits into the format's fields; other bits come from base.
    always_comb begin
        enc_c = s1_q.base;
        case (s1_q.src)
            SRC_I: enc_c[31:20] = s1_q.imm[11:0];
            SRC_S: begin
                enc_c[31:25] = s1_q.imm[11:5];
                enc_c[11:7]  = s1_q.imm[4:0];
            end
            SRC_B: begin
                enc_c[31]    = s1_q.imm[12];
                enc_c[30:25] = s1_q.imm[10:5];
                enc_c[11:8]  = s1_q.imm[4:1];
                enc_c[7]     = s1_q.imm[11];
            end
            SRC_U: enc_c[31:12] = s1_q.imm[31:12];
            SRC_J: begin
                enc_c[31]    = s1_q.imm[20];
                enc_c[30:21] = s1_q.imm[10:1];
                enc_c[20]    = s1_q.imm[11];
                enc_c[19:12] = s1_q.imm[19:12];
            end
            default: enc_c = s1_q.base;
        endcase
    end

    // A rejected stage-1 item drains on its own even while stage 2 is stalled.
    assign out_xfer_c = out_valid && out_ready;
    assign s2_load_c  = !out_valid || out_ready;
    assign s1_adv_c   = s1_valid && (s2_load_c || s1_bad_c);
    assign s1_pass_c  = s1_valid && !s1_bad_c;
    assign in_ready   = !clear && (!s1_valid || s1_adv_c);
    assign in_xfer_c  = in_valid && in_ready;

    // Stage 1: capture the input item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (in_xfer_c) begin
            s1_valid <= 1'b1;
            s1_q     <= '{src: imm_src, base: base_instr, imm: imm};
        end else if (s1_adv_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: encoded word and its write address; address advances per transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_addr  <= BASE;
        end else begin
            if (out_xfer_c) begin
                out_addr <= out_addr + ADDR_W'(1);
            end
            if (s2_load_c) begin
                out_valid <= s1_pass_c;
                if (s1_pass_c) begin
                    out_instr <= enc_c;
                end
            end
        end
    end

    // Error accounting for items dropped out of stage 1.
`ifdef IMM_ENC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clear) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (s1_valid && s1_bad_c) begin
            err_sticky <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`else
    assign err_cnt    = 8'd0;
    assign err_sticky = 1'b0;
`endif

endmodule
